// File: rtl/mm_pkg.sv
// Shared definitions for the sequential dot-product engine.
//   DATA_W  : operand width of the row/column mux_16 sources
//   VEC_LEN : elements per dot product (1..16)
//   ACC_W   : accumulator/result width, 2*DATA_W+4 so 16 full-scale
//             products never overflow
//   SEL_W   : width of the element index driven to both mux_16 sel ports
//   state_t : controller states
package mm_pkg;

  localparam int DATA_W  = 16;
  localparam int VEC_LEN = 16;
  localparam int ACC_W   = 2 * DATA_W + 4;
  localparam int SEL_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath for dot_product_seq.
// Registers one unsigned product per enabled cycle, then folds it into
// the accumulator on the following cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : zero the accumulator (start of a new dot product)
//   en_i       : capture a_i*b_i into the product register this cycle
//   a_i, b_i   : unsigned operands
//   acc_nxt_o  : value the accumulator takes at the next edge
//                (acc + pending product), used to load the result
module mac_unit #(
  parameter int DATA_W = mm_pkg::DATA_W,
  parameter int ACC_W  = mm_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_nxt_o
);

  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic                prod_vld_q;
  logic [ACC_W-1:0]    acc_q, acc_d;

  always_comb begin
    prod_d = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    if (prod_vld_q) begin
      acc_nxt_o = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, prod_q};
    end else begin
      acc_nxt_o = acc_q;
    end
    acc_d = clear_i ? '0 : acc_nxt_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      if (en_i) begin
        prod_q <= prod_d;
      end
      // A product is pending only in the cycle after a capture.
      prod_vld_q <= en_i;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: rtl/dot_product_seq.sv
// Sequential dot-product engine. Steps an element index through two
// external mux_16 sources, multiplies the selected operands and
// accumulates them, then presents the unsigned sum on result.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a dot product (sampled in IDLE and DONE only)
//   a_in     : row operand selected by sel
//   b_in     : column operand selected by sel
//   sel      : registered element index to both mux_16 sel ports
//   busy     : high while in RUN or DRAIN
//   done     : one-cycle pulse when result has just been updated
//   result   : sum of a[i]*b[i], held until the next done
module dot_product_seq #(
  parameter int DATA_W  = mm_pkg::DATA_W,
  parameter int VEC_LEN = mm_pkg::VEC_LEN,
  parameter int ACC_W   = mm_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        a_in,
  input  logic [DATA_W-1:0]        b_in,
  output logic [mm_pkg::SEL_W-1:0] sel,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-1:0]         result
);
  import mm_pkg::*;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(VEC_LEN - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [ACC_W-1:0] acc_nxt;
  logic             mac_clear;
  logic             mac_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mac_clear = 1'b1;
          cnt_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        mac_en = 1'b1;
        if (cnt_q == LAST_IDX) begin
          // Index returns to 0 so sel is 0 for the rest of the run.
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + SEL_W'(1);
        end
      end
      S_DRAIN: begin
        // The final product is still pending; acc_nxt includes it.
        result_d = acc_nxt;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          mac_clear = 1'b1;
          cnt_d     = '0;
          state_d   = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (mac_clear),
    .en_i      (mac_en),
    .a_i       (a_in),
    .b_i       (b_in),
    .acc_nxt_o (acc_nxt)
  );

  // Outputs decode registered state only; no path from a_in/b_in.
  assign sel    = cnt_q;
  assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: doc/dot_product_seq.md
DOT_PRODUCT_SEQ -- requirements
Module: dot_product_seq

Interface
REQ-001 Parameter DATA_W, default 16: operand width, matching the mux_16 data width.
REQ-002 Parameter VEC_LEN, default 16: elements per dot product, legal range 1..16.
REQ-003 Parameter ACC_W, default 36: accumulator and result width, equal to 2*DATA_W+4.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to begin one dot product; a single-cycle pulse is sufficient.
REQ-007 a_in  input  DATA_W  row operand, the combinational out of the row mux_16 driven by sel.
REQ-008 b_in  input  DATA_W  column operand, the combinational out of the column mux_16 driven by sel.
REQ-009 sel  output  4  element index driven to both mux_16 sel ports; registered.
REQ-010 busy  output  1  high in RUN and DRAIN.
REQ-011 done  output  1  one-cycle pulse when result is updated.
REQ-012 result  output  ACC_W  unsigned sum of a[i]*b[i] for i=0..VEC_LEN-1, held until the next done.

Function
REQ-013 FSM states shall be IDLE, RUN, DRAIN and DONE.
REQ-014 IDLE: sel=0, busy=0, done=0; start=1 clears acc and the element counter and moves to RUN.
REQ-015 RUN: sel equals the counter; each cycle prod_q <= a_in*b_in, prod_vld <= 1, and the counter increments.
REQ-016 RUN shall last exactly VEC_LEN cycles; at counter==VEC_LEN-1 the FSM moves to DRAIN and sel returns to 0.
REQ-017 Each cycle with prod_vld=1 shall perform acc <= acc + prod_q; prod_vld=0 in every state except the cycle following a RUN cycle.
REQ-018 DRAIN: exactly one cycle, adding the final product; result <= acc + prod_q; the FSM then moves to DONE.
REQ-019 DONE: done=1 for exactly one cycle; start=1 here moves to RUN (back-to-back run); otherwise the FSM moves to IDLE.
REQ-020 Latency: with start sampled at edge E, sel=0 is valid after E, and done is high in cycle E+VEC_LEN+2, counted in edges.
REQ-021 Products shall be unsigned DATA_W x DATA_W -> 2*DATA_W; accumulation shall use ACC_W, with no overflow possible for VEC_LEN<=16.
REQ-022 start during RUN or DRAIN shall be ignored, with no effect on sel, acc or timing.
REQ-023 a_in and b_in shall be sampled only in RUN cycles; values in other states are don't-care.
REQ-024 result shall change only on the edge entering DONE.
REQ-025 VEC_LEN=1: RUN lasts one cycle with sel=0, and done follows 3 edges after start.

Reset
REQ-026 rst=1 shall immediately force state=IDLE, sel=0, busy=0, done=0, result=0, acc=0, prod_q=0, prod_vld=0 and counter=0, regardless of clk.
REQ-027 Reset mid-RUN or mid-DRAIN shall abandon the operation with no done pulse; the first start after reset release behaves as in REQ-014.

Structure
REQ-028 Package mm_pkg shall hold DATA_W, VEC_LEN, ACC_W, the state enum type and the sel width constant (4).
REQ-029 A single sub-module mac_unit shall contain the product register, prod_vld and the accumulator, controlled by clear and enable from the FSM.
REQ-030 The FSM and the element counter shall reside in dot_product_seq; there shall be no combinational path from a_in or b_in to any output.

Verification
REQ-031 Two mux_16 sources with a[i]=i+1, b[i]=1, one start pulse -> sel steps 0..15, result=136, done high at E+18, busy high for 17 cycles.
REQ-032 a[i]=b[i]=16'hFFFF for all i -> result=36'hFFFE00010, with no truncation.
REQ-033 start held high continuously for 3 runs, a[i]=i, b[i]=2 -> done every 18 cycles, result=240 each time, and sel sequence 0..15 repeats without gaps beyond DRAIN/DONE.
REQ-034 Extra start pulses during RUN (at sel=5) and in DRAIN -> ignored, exactly one done, and result as in REQ-031.
REQ-035 rst asserted asynchronously mid-RUN at sel=7 -> sel, busy, done and result are 0 before the next edge, with no done; a following start then yields 136.
REQ-036 All operands 0 -> done still pulses at E+18 with result=0; after a prior run, result goes from 136 to 0 exactly at done.
